// File: rtl/uart_bus_ctrl.sv
// rtl/uart_bus_ctrl.sv - memory-mapped UART controller: TX byte queue, TX PHY sequencer, RX capture
//
// Purpose:
//   Sits between the CPU data bus and the UART TX/RX PHYs. CPU writes to TXD are
//   queued and handed to the TX PHY one at a time with a start/busy handshake.
//   Received bytes are latched into RXD with full/overrun status. Bus reads are
//   combinational on bus_addr.
//
// Optional feature (macro UART_IRQ_EN):
//   defined   - CON[1:0] are interrupt enables, irq is a registered request.
//   undefined - irq tied low, CON[1:0] read as 0 and ignore writes.
//
// Ports:
//   clk        in   1   system clock
//   reset      in   1   synchronous active-high reset
//   bus_addr   in   32  CPU byte address
//   bus_wdata  in   32  CPU write data
//   bus_we     in   1   write strobe
//   bus_rd     in   1   read strobe (RXD read clears rx_full at the edge)
//   bus_rdata  out  32  combinational read data, 0 for unmapped addresses
//   tx_start   out  1   one-cycle start pulse to the TX PHY
//   tx_data    out  8   byte for the TX PHY, held after tx_start
//   tx_busy    in   1   TX PHY frame in progress
//   rx_valid   in   1   RX PHY byte strobe
//   rx_data    in   8   received byte
//   irq        out  1   registered interrupt request

module uart_bus_ctrl #(
  parameter int unsigned TXQ_DEPTH = 4,
  parameter logic [31:0] ADDR_TXD  = 32'h4000_0018,
  parameter logic [31:0] ADDR_RXD  = 32'h4000_001C,
  parameter logic [31:0] ADDR_CON  = 32'h4000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  input  logic        bus_rd,
  output logic [31:0] bus_rdata,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        irq
);

  localparam int unsigned PW      = $clog2(TXQ_DEPTH);
  localparam logic [4:0]  DEPTH_C = 5'(TXQ_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } tx_state_e;

  tx_state_e      state_q, state_d;
  logic [7:0]     txq_q [TXQ_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [4:0]     count_q, count_d;
  logic           tx_start_q, tx_start_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic [7:0]     rxd_q, rxd_d;
  logic           rx_full_q, rx_full_d;
  logic           rx_ovf_q, rx_ovf_d;
  logic           tx_ovf_q, tx_ovf_d;
  logic           tx_irq_en_q, tx_irq_en_d;
  logic           rx_irq_en_q, rx_irq_en_d;
  logic           irq_q, irq_d;

  logic wr_txd, wr_con, rd_rxd;
  logic tx_full, tx_empty, push, pop;
  logic [31:0] con;
  logic unused_wdata;

  assign unused_wdata = ^bus_wdata[31:8];

  assign wr_txd   = bus_we && (bus_addr == ADDR_TXD);
  assign wr_con   = bus_we && (bus_addr == ADDR_CON);
  assign rd_rxd   = bus_rd && (bus_addr == ADDR_RXD);
  // Fullness uses the registered count, so a same-cycle pop never makes room.
  assign tx_full  = (count_q == DEPTH_C);
  assign tx_empty = (count_q == 5'd0) && (state_q == S_IDLE);
  assign push     = wr_txd && !tx_full;

  // TX sequencer
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != 5'd0) begin
          pop        = 1'b1;
          tx_data_d  = txq_q[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: if (tx_busy)  state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx_busy) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // Status, RX capture and control bits
  always_comb begin
    rxd_d       = rxd_q;
    rx_full_d   = rx_full_q;
    rx_ovf_d    = rx_ovf_q;
    tx_ovf_d    = tx_ovf_q;
    tx_irq_en_d = tx_irq_en_q;
    rx_irq_en_d = rx_irq_en_q;
    irq_d       = 1'b0;

    // W1C first so a same-cycle overflow event still sets the flag.
    if (wr_con && bus_wdata[5]) rx_ovf_d = 1'b0;
    if (wr_con && bus_wdata[6]) tx_ovf_d = 1'b0;
    if (wr_txd && tx_full)      tx_ovf_d = 1'b1;

    // A coinciding RXD read consumes the old byte; the new one keeps rx_full set.
    if (rx_valid) begin
      rxd_d     = rx_data;
      rx_full_d = 1'b1;
      if (rx_full_q && !rd_rxd) rx_ovf_d = 1'b1;
    end else if (rd_rxd) begin
      rx_full_d = 1'b0;
    end

`ifdef UART_IRQ_EN
    if (wr_con) begin
      tx_irq_en_d = bus_wdata[0];
      rx_irq_en_d = bus_wdata[1];
    end
    irq_d = (tx_irq_en_q && tx_empty) || (rx_irq_en_q && rx_full_q);
`else
    tx_irq_en_d = 1'b0;
    rx_irq_en_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      rxd_q       <= '0;
      rx_full_q   <= 1'b0;
      rx_ovf_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      tx_irq_en_q <= 1'b0;
      rx_irq_en_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q     <= count_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      rxd_q       <= rxd_d;
      rx_full_q   <= rx_full_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_ovf_q    <= tx_ovf_d;
      tx_irq_en_q <= tx_irq_en_d;
      rx_irq_en_q <= rx_irq_en_d;
      irq_q       <= irq_d;
    end
  end

  // Queue storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (!reset && push) txq_q[wr_ptr_q] <= bus_wdata[7:0];
  end

  always_comb begin
    con       = '0;
    con[0]    = tx_irq_en_q;
    con[1]    = rx_irq_en_q;
    con[2]    = rx_full_q;
    con[3]    = tx_empty;
    con[4]    = tx_full;
    con[5]    = rx_ovf_q;
    con[6]    = tx_ovf_q;
    con[12:8] = count_q;
    bus_rdata = '0;
    if (bus_addr == ADDR_RXD)      bus_rdata = {24'd0, rxd_q};
    else if (bus_addr == ADDR_CON) bus_rdata = con;
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign irq      = irq_q;

endmodule
